// File: rtl/sie_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sie_defs_pkg : constants shared by the full-speed SIE transmit path   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sie_defs_pkg;

   localparam logic [7:0] SYNC_VALUE        = 8'h80;
   localparam int         STUFF_LIMIT_DEF   = 6;
   localparam logic       LEVEL_J           = 1'b1;
   localparam logic       LEVEL_K           = 1'b0;
   localparam int         BIT_CNT_W         = 4;

   typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

   // A 0 bit is signalled by a line transition, a 1 bit by holding the level.
   function automatic logic nrziNext(input logic level, input logic bitIn);
      return bitIn ? level : ~level;
   endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_bit_pipeline_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_bit_pipeline_if : byte handshake between tx FSM and bit path   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface usb_tx_bit_pipeline_if;

   logic       clear;
   logic       load;
   logic [7:0] load_data;
   logic       req_new;
   logic       ser_bit;
   logic       ser_bit_valid;
   logic       stuffed_bit;
   logic       nrzi_out;
   logic       active;

   modport master (
      output clear, load, load_data,
      input  req_new, ser_bit, ser_bit_valid, stuffed_bit, nrzi_out, active
   );

   modport slave (
      input  clear, load, load_data,
      output req_new, ser_bit, ser_bit_valid, stuffed_bit, nrzi_out, active
   );

endinterface
`default_nettype wire

// File: rtl/nrzi_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nrzi_encoder : registered NRZI line level                             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module nrzi_encoder
   import sie_defs_pkg::*;
#(
   parameter logic IDLE_LEVEL = LEVEL_J
) (
   input  wire logic clk12,
   input  wire logic RST_N,
   input  wire logic clear,
   input  wire logic bit_tick,
   input  wire logic stuffed_bit,
   output logic      level
);

   always_ff @(posedge clk12 or negedge RST_N) begin
      if (!RST_N) begin
         level <= IDLE_LEVEL;
      end else if (clear) begin
         level <= IDLE_LEVEL;
      end else if (bit_tick) begin
         level <= nrziNext(level, stuffed_bit);
      end
   end

endmodule
`default_nettype wire

// File: rtl/output_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_shift_reg : LSB-first byte serializer with gap-free reload     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module output_shift_reg
   import sie_defs_pkg::*;
(
   input  wire logic       clk12,
   input  wire logic       RST_N,
   input  wire logic       clear,
   input  wire logic       load,
   input  wire logic [7:0] load_data,
   input  wire logic       stall,
   output logic            ser_bit,
   output logic            ser_bit_valid,
   output logic            req_new,
   output logic            active
);

   logic [7:0] r_sr;
   bit_cnt_t   r_cnt;

   assign ser_bit       = r_sr[0];
   assign active        = (r_cnt != '0);
   assign ser_bit_valid = active & ~stall;
   // Request while the last bit is leaving so the next byte follows without a gap.
   assign req_new       = (r_cnt == '0) | ((r_cnt == bit_cnt_t'(1)) & ser_bit_valid);

   always_ff @(posedge clk12 or negedge RST_N) begin
      if (!RST_N) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (clear) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (load && req_new) begin
         r_sr  <= load_data;
         r_cnt <= bit_cnt_t'(8);
      end else if (ser_bit_valid) begin
         r_sr  <= {1'b0, r_sr[7:1]};
         r_cnt <= r_cnt - bit_cnt_t'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/usb_bit_stuff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_bit_stuff : inserts a 0 after STUFF_LIMIT consecutive 1s          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module usb_bit_stuff
   import sie_defs_pkg::*;
#(
   parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
   input  wire logic clk12,
   input  wire logic RST_N,
   input  wire logic clear,
   input  wire logic ser_bit,
   input  wire logic ser_bit_valid,
   output logic      stall,
   output logic      stuffed_bit,
   output logic      bit_tick
);

   localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

   logic [ONES_W-1:0] r_onesCnt;

   // Stall depends only on the count, so a trailing stuff is still sent after the byte ends.
   assign stall    = (r_onesCnt == ONES_W'(STUFF_LIMIT));
   assign bit_tick = ser_bit_valid | stall;

   always_comb begin
      stuffed_bit = 1'b1;
      if (stall) begin
         stuffed_bit = 1'b0;
      end else if (ser_bit_valid) begin
         stuffed_bit = ser_bit;
      end
   end

   always_ff @(posedge clk12 or negedge RST_N) begin
      if (!RST_N) begin
         r_onesCnt <= '0;
      end else if (clear || stall) begin
         r_onesCnt <= '0;
      end else if (ser_bit_valid) begin
         r_onesCnt <= ser_bit ? r_onesCnt + 1'b1 : '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/usb_tx_bit_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_bit_pipeline : serializer -> bit stuffer -> NRZI line encoder  |
// | Option macro USB_TX_OUT_REG_EN adds an output flop on nrzi_out.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module usb_tx_bit_pipeline
   import sie_defs_pkg::*;
#(
   parameter logic IDLE_LEVEL  = LEVEL_J,
   parameter int   STUFF_LIMIT = STUFF_LIMIT_DEF
) (
   input  wire logic              clk12,
   input  wire logic              RST_N,
   usb_tx_bit_pipeline_if.slave   bus
);

   logic w_stall;
   logic w_serBit;
   logic w_serValid;
   logic w_stuffedBit;
   logic w_bitTick;
   logic w_nrziLevel;

   output_shift_reg u_ser (
      .clk12         (clk12),
      .RST_N         (RST_N),
      .clear         (bus.clear),
      .load          (bus.load),
      .load_data     (bus.load_data),
      .stall         (w_stall),
      .ser_bit       (w_serBit),
      .ser_bit_valid (w_serValid),
      .req_new       (bus.req_new),
      .active        (bus.active)
   );

   usb_bit_stuff #(
      .STUFF_LIMIT (STUFF_LIMIT)
   ) u_stuff (
      .clk12         (clk12),
      .RST_N         (RST_N),
      .clear         (bus.clear),
      .ser_bit       (w_serBit),
      .ser_bit_valid (w_serValid),
      .stall         (w_stall),
      .stuffed_bit   (w_stuffedBit),
      .bit_tick      (w_bitTick)
   );

   nrzi_encoder #(
      .IDLE_LEVEL (IDLE_LEVEL)
   ) u_nrzi (
      .clk12       (clk12),
      .RST_N       (RST_N),
      .clear       (bus.clear),
      .bit_tick    (w_bitTick),
      .stuffed_bit (w_stuffedBit),
      .level       (w_nrziLevel)
   );

   assign bus.ser_bit       = w_serBit;
   assign bus.ser_bit_valid = w_serValid;
   assign bus.stuffed_bit   = w_stuffedBit;

`ifdef USB_TX_OUT_REG_EN
   logic r_lineOut;

   always_ff @(posedge clk12 or negedge RST_N) begin
      if (!RST_N) begin
         r_lineOut <= IDLE_LEVEL;
      end else if (bus.clear) begin
         r_lineOut <= IDLE_LEVEL;
      end else begin
         r_lineOut <= w_nrziLevel;
      end
   end

   assign bus.nrzi_out = r_lineOut;
`else
   assign bus.nrzi_out = w_nrziLevel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_bit_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_usb_tx_bit_pipeline : directed vectors for the tx bit pipeline     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_usb_tx_bit_pipeline;
   import sie_defs_pkg::*;

   logic clk12 = 1'b0;
   logic rstN;
   int   checkCnt = 0;
   int   passCnt  = 0;

   usb_tx_bit_pipeline_if bus ();

   usb_tx_bit_pipeline u_dut (
      .clk12 (clk12),
      .RST_N (rstN),
      .bus   (bus)
   );

   always #5 clk12 = ~clk12;

   task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checkCnt++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else passCnt++;
   endtask

   task automatic doClear();
      bus.clear = 1'b1;
      @(negedge clk12);
      bus.clear = 1'b0;
   endtask

   initial begin
      logic [7:0]  syncByte;
      logic [7:0]  syncNrziAfter;
      logic [15:0] chainBits;
      logic [7:0]  fcByte;
      logic        isStall;

      syncByte      = SYNC_VALUE;
      syncNrziAfter = 8'b0010_1010;   // after-edge levels 0,1,0,1,0,1,0,0 indexed by bit
      chainBits     = 16'hA580;
      fcByte        = 8'hFC;

      rstN = 1'b0;
      bus.clear = 1'b0;
      bus.load = 1'b0;
      bus.load_data = 8'h00;
      repeat (2) @(negedge clk12);
      checkEq("rst_req_new",  16'(bus.req_new), 16'd1);
      checkEq("rst_active",   16'(bus.active), 16'd0);
      checkEq("rst_valid",    16'(bus.ser_bit_valid), 16'd0);
      checkEq("rst_nrzi",     16'(bus.nrzi_out), 16'd1);
      checkEq("rst_stuffed",  16'(bus.stuffed_bit), 16'd1);
      rstN = 1'b1;
      @(negedge clk12);

      // SYNC pattern, with clear beating a simultaneous load
      bus.clear = 1'b1; bus.load = 1'b1; bus.load_data = 8'hFF;
      @(negedge clk12);
      bus.clear = 1'b0;
      checkEq("clr_over_load_active", 16'(bus.active), 16'd0);
      bus.load_data = syncByte;
      @(negedge clk12);
      bus.load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkEq($sformatf("sync_stuffed[%0d]", i), 16'(bus.stuffed_bit), 16'(syncByte[i]));
         checkEq($sformatf("sync_valid[%0d]", i), 16'(bus.ser_bit_valid), 16'd1);
         checkEq($sformatf("sync_req[%0d]", i), 16'(bus.req_new), 16'(i == 7));
         checkEq($sformatf("sync_nrzi[%0d]", i), 16'(bus.nrzi_out),
                 (i == 0) ? 16'd1 : 16'(syncNrziAfter[i-1]));
         @(negedge clk12);
      end
      checkEq("sync_nrzi_end",   16'(bus.nrzi_out), 16'(syncNrziAfter[7]));
      checkEq("sync_active_end", 16'(bus.active), 16'd0);
      checkEq("sync_valid_end",  16'(bus.ser_bit_valid), 16'd0);
      checkEq("sync_idle_bit",   16'(bus.stuffed_bit), 16'd1);
      @(negedge clk12);
      checkEq("sync_nrzi_hold",  16'(bus.nrzi_out), 16'd0);

      // Back-to-back 80,A5 with an ignored load mid-byte
      doClear();
      bus.load = 1'b1; bus.load_data = 8'h80;
      @(negedge clk12);
      bus.load = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         checkEq($sformatf("chain_valid[%0d]", i), 16'(bus.ser_bit_valid), 16'd1);
         checkEq($sformatf("chain_bit[%0d]", i), 16'(bus.ser_bit), 16'(chainBits[i-1]));
         checkEq($sformatf("chain_req[%0d]", i), 16'(bus.req_new), 16'(i == 8 || i == 16));
         bus.load      = (i == 3) || (i == 8);
         bus.load_data = (i == 3) ? 8'hFF : 8'hA5;
         @(negedge clk12);
      end
      bus.load = 1'b0;
      checkEq("chain_valid_end", 16'(bus.ser_bit_valid), 16'd0);
      checkEq("chain_nrzi_end",  16'(bus.nrzi_out), 16'd0);

      // FF,FF: stuffed zeros after the 6th and 12th one
      doClear();
      bus.load = 1'b1; bus.load_data = 8'hFF;
      @(negedge clk12);
      bus.load = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         isStall = (i == 7) || (i == 14);
         checkEq($sformatf("ff_stuffed[%0d]", i), 16'(bus.stuffed_bit), 16'(!isStall));
         checkEq($sformatf("ff_valid[%0d]", i), 16'(bus.ser_bit_valid), 16'(!isStall));
         checkEq($sformatf("ff_req[%0d]", i), 16'(bus.req_new), 16'(i == 9 || i == 18));
         checkEq($sformatf("ff_nrzi[%0d]", i), 16'(bus.nrzi_out),
                 16'((i <= 7) || (i >= 15)));
         bus.load      = (i == 9);
         bus.load_data = 8'hFF;
         @(negedge clk12);
      end
      bus.load = 1'b0;
      checkEq("ff_active_end", 16'(bus.active), 16'd0);
      checkEq("ff_nrzi_end",   16'(bus.nrzi_out), 16'd1);

      // FC: six trailing ones force a stuff after the byte has ended
      doClear();
      bus.load = 1'b1; bus.load_data = fcByte;
      @(negedge clk12);
      bus.load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkEq($sformatf("fc_stuffed[%0d]", i), 16'(bus.stuffed_bit), 16'(fcByte[i]));
         @(negedge clk12);
      end
      checkEq("fc_tail_stuffed", 16'(bus.stuffed_bit), 16'd0);
      checkEq("fc_tail_valid",   16'(bus.ser_bit_valid), 16'd0);
      checkEq("fc_tail_active",  16'(bus.active), 16'd0);
      checkEq("fc_tail_nrzi",    16'(bus.nrzi_out), 16'd1);
      @(negedge clk12);
      checkEq("fc_idle_stuffed", 16'(bus.stuffed_bit), 16'd1);
      checkEq("fc_after_nrzi",   16'(bus.nrzi_out), 16'd0);
      @(negedge clk12);
      checkEq("fc_hold_nrzi",    16'(bus.nrzi_out), 16'd0);

      // Asynchronous reset three bits into 55
      doClear();
      bus.load = 1'b1; bus.load_data = 8'h55;
      @(negedge clk12);
      bus.load = 1'b0;
      repeat (3) @(negedge clk12);
      checkEq("mid_nrzi_pre",   16'(bus.nrzi_out), 16'd0);
      checkEq("mid_active_pre", 16'(bus.active), 16'd1);
      rstN = 1'b0;
      #1;
      checkEq("mid_rst_nrzi",   16'(bus.nrzi_out), 16'd1);
      checkEq("mid_rst_active", 16'(bus.active), 16'd0);
      checkEq("mid_rst_req",    16'(bus.req_new), 16'd1);
      @(negedge clk12);
      checkEq("mid_rst_hold",   16'(bus.active), 16'd0);
      rstN = 1'b1;
      bus.load = 1'b1; bus.load_data = 8'h80;
      @(negedge clk12);
      bus.load = 1'b0;
      checkEq("restart_valid",   16'(bus.ser_bit_valid), 16'd1);
      checkEq("restart_bit",     16'(bus.ser_bit), 16'd0);
      checkEq("restart_nrzi",    16'(bus.nrzi_out), 16'd1);
      @(negedge clk12);
      checkEq("restart_nrzi_k",  16'(bus.nrzi_out), 16'd0);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
`default_nettype wire
